md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS pipeline.
- Sits in the EXE stage beside the ALU. It executes MULT/MULTU/DIV/DIVU as multi-cycle operations and MTHI/MTLO as single-cycle writes.
- Drives busy so the hazard logic can stall any MFHI/MFLO or new MD instruction.
- Generalises the single-cycle ALU path: width is parametrised, it has a start/busy/done handshake, and it honours the pipeline's cpu_en/flush controls.

Parameters:
- WIDTH, 32: operand width; HI and LO are WIDTH bits each.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  main clock; all state changes on rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- cpu_en  in  1  global enable; when low, all state (FSM, counter, HI/LO, done) holds.
- flush  in  1  aborts an in-flight operation; HI/LO are not modified.
- start  in  1  issue request, sampled only in IDLE with cpu_en=1.
- oper  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- opa  in  WIDTH  rs operand (dividend, multiplicand, or MT data).
- opb  in  WIDTH  rt operand (divisor or multiplier).
- busy  out  1  high while an MD operation occupies the unit.
- done  out  1  one-cycle pulse in the cycle when new HI/LO first become visible.
- div_by_zero  out  1  valid with done; high when the divisor was 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: FSM=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0. Reset has priority over everything else, including mid-operation: any in-flight operation is discarded.
- cpu_en=0 freezes everything; done holds its value.
- States: IDLE, RUN, FIX.
  - IDLE: on start & cpu_en & ~flush with oper 0..3, latch operands. For signed ops, latch absolute values and record the result signs. Clear the counter and go to RUN.
  - IDLE: oper 4 writes hi<=opa and oper 5 writes lo<=opa at that edge. The FSM stays in IDLE; busy and done are not asserted.
  - RUN: one radix-2 step per enabled cycle (shift-add for multiply, restoring shift-subtract for divide), exactly WIDTH cycles. Move to FIX when counter==WIDTH-1.
  - FIX: apply sign correction. Write hi/lo, pulse done, go to IDLE.
- Latency: start accepted at edge E0. busy=1 for WIDTH+1 cycles (E0+1 .. E0+WIDTH+1). hi/lo are updated at edge E0+WIDTH+1 and done=1 for the following cycle only. Stalled cpu_en cycles add to this latency one-for-one.
- Multiply: the 2*WIDTH-bit product goes to {hi,lo}. MULT is two's-complement signed; MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - Signed INT_MIN / -1 gives lo=INT_MIN, hi=0, with no trap.
  - Divisor 0: the full iteration time still elapses. Result is hi=opa (dividend), lo=all ones, div_by_zero=1 during done.
- div_by_zero is 0 whenever done=0.
- start while busy is ignored; the hazard logic must stall.
- flush in RUN/FIX (with cpu_en=1): go to IDLE at that edge, busy=0 next cycle, no done, hi/lo unchanged.
- flush in IDLE blocks acceptance of a simultaneous start, including MTHI/MTLO.
- FIX edge with flush=1: flush wins and hi/lo are not written.
- hi/lo are direct register outputs; there is no combinational path from opa/opb.

Test Plan:
- MULT opa=0xFFFFFFFF, opb=7 -> busy 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF9, done one cycle. MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFF9.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> after 33 cycles hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1 coincident with done, then 0 next cycle.
- MTHI 0xDEADBEEF then MTLO 0x0BADF00D on consecutive cycles -> hi/lo updated on the edge after each. busy never rises and there is no done pulse.
- Start a MULT, pulse start again with other operands at cycle 5 -> second request ignored. Assert flush at cycle 10 -> busy=0 next cycle, hi/lo keep their prior values, no done.
- DIVU 100 / 7 with cpu_en=0 for 5 cycles mid-RUN -> done arrives exactly 5 cycles later than nominal with the correct result. cpu_rst at RUN cycle 12 -> hi=lo=0, busy=done=0 on the next cycle.

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative multiply/divide unit with HI/LO registers
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign-fixed in FIX.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             cpu_rst,
  input  logic             cpu_en,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, operand;
  logic               is_div, neg_q, neg_r, dz;

  logic               signed_op, a_neg, b_neg, last_step, div_ok;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem, fix_hi, fix_lo;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] prod;

  assign busy      = (state != IDLE);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    signed_op = ~oper[0];
    a_neg     = signed_op & opa[WIDTH-1];
    b_neg     = signed_op & opb[WIDTH-1];
    abs_a     = a_neg ? -opa : opa;
    abs_b     = b_neg ? -opb : opb;
  end

  // acc_hi:acc_lo is the running product (multiply) or remainder:dividend-quotient (divide)
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, operand};
    div_ok    = ~div_trial[WIDTH];
  end

  always_comb begin
    prod = {acc_hi, acc_lo};
    if (neg_q) prod = -prod;
    quo = dz ? {WIDTH{1'b1}} : (neg_q ? -acc_lo : acc_lo);
    rem = neg_r ? -acc_hi : acc_hi;
    fix_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo = is_div ? quo : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (cpu_rst) state <= IDLE;
    else if (cpu_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !flush && !oper[2]) state_nxt = RUN;
      RUN:  if (flush) state_nxt = IDLE;
            else if (last_step) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      operand     <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (cpu_en) begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            if (!oper[2]) begin
              is_div  <= oper[1];
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              dz      <= oper[1] & (opb == '0);
              operand <= oper[1] ? abs_b : abs_a;
              acc_lo  <= oper[1] ? abs_a : abs_b;
              acc_hi  <= '0;
              cnt     <= '0;
            end else if (oper == 3'd4) begin
              hi <= opa;
            end else if (oper == 3'd5) begin
              lo <= opa;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
              acc_hi <= div_ok ? div_trial[WIDTH-1:0] : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
              acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          if (!flush) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            done        <= 1'b1;
            div_by_zero <= is_div & dz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit
// Random and directed MD operations checked against an arithmetic reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        cpu_rst, cpu_en, flush, start;
  logic [2:0]  oper;
  logic [31:0] opa, opb;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  md_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .cpu_rst(cpu_rst), .cpu_en(cpu_en), .flush(flush), .start(start),
    .oper(oper), .opa(opa), .opb(opb), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic dzo);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    dzo = 1'b0;
    p = '0;
    case (o)
      3'd0: p = sa * sb;
      3'd1: p = ua * ub;
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
          dzo = 1'b1;
        end else if (o == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {32'(ua % ub), 32'(ua / ub)};
        end
      end
      default: ;
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Issues one operation and reports what was seen; callers do the comparisons.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input int stall_len,
                        output int lat, output int busy_cnt, output logic [31:0] h,
                        output logic [31:0] l, output logic dzv,
                        output logic done_after, output logic dz_after);
    @(negedge clk);
    oper = o; opa = a; opb = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_cnt++;
      if (lat == stall_at) cpu_en = 1'b0;
      if (lat == stall_at + stall_len) cpu_en = 1'b1;
      @(negedge clk);
      lat++;
    end
    cpu_en = 1'b1;
    h = hi; l = lo; dzv = div_by_zero;
    @(negedge clk);
    done_after = done;
    dz_after = div_by_zero;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1; cpu_en = 1'b1; flush = 1'b0; start = 1'b0;
    oper = 3'd0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    cpu_rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", div_by_zero); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2};
    logic [31:0] as  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100,
                             32'h8000_0000, 32'h1234, 32'hFFFF_FF00};
    logic [31:0] bs  [7] = '{32'd7, 32'd7, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
    int lat, bc;
    logic [31:0] h, l, eh, el;
    logic dzv, da, dza, edz;
    for (int i = 0; i < 7; i++) begin
      ref_md(ops[i], as[i], bs[i], eh, el, edz);
      run_op(ops[i], as[i], bs[i], -1, 0, lat, bc, h, l, dzv, da, dza);
      checks++; if (lat !== 34) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=34", i, lat); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, bc); end
      checks++; if (h !== eh) begin errors++; $display("FAIL dir%0d_hi got=%h exp=%h", i, h, eh); end
      checks++; if (l !== el) begin errors++; $display("FAIL dir%0d_lo got=%h exp=%h", i, l, el); end
      checks++; if (dzv !== edz) begin errors++; $display("FAIL dir%0d_dz got=%b exp=%b", i, dzv, edz); end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, da); end
      checks++; if (dza !== 1'b0) begin errors++; $display("FAIL dir%0d_dz_after got=%b exp=0", i, dza); end
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [2:0]  o;
    logic [31:0] a, b, h, l, eh, el;
    logic dzv, da, dza, edz;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = -a;
        default: ;
      endcase
      ref_md(o, a, b, eh, el, edz);
      run_op(o, a, b, -1, 0, lat, bc, h, l, dzv, da, dza);
      checks++; if (lat !== 34) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=34", i, lat); end
      checks++; if ({h, l} !== {eh, el}) begin
        errors++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, o, a, b, h, l, eh, el);
      end
      checks++; if (dzv !== edz) begin errors++; $display("FAIL rnd%0d_dz got=%b exp=%b", i, dzv, edz); end
    end
  endtask

  task automatic test_mt();
    logic [31:0] ph, pl;
    @(negedge clk);
    oper = 3'd4; opa = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk);
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi got=%h exp=deadbeef", hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_busy_done got=%b%b exp=00", busy, done); end
    oper = 3'd5; opa = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL mtlo_lo got=%h exp=0badf00d", lo); end
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_hi_kept got=%h exp=deadbeef", hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_busy_done got=%b%b exp=00", busy, done); end
    // flush in IDLE blocks both MT writes and MD starts
    ph = hi; pl = lo;
    oper = 3'd4; opa = 32'h1111_2222; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    oper = 3'd2; opb = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++; if (hi !== ph) begin errors++; $display("FAIL flush_idle_hi got=%h exp=%h", hi, ph); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
    checks++; if (lo !== pl) begin errors++; $display("FAIL flush_idle_lo got=%h exp=%h", lo, pl); end
  endtask

  task automatic test_ignore_start();
    logic [31:0] eh, el;
    logic edz;
    int cyc;
    ref_md(3'd0, 32'h0001_2345, 32'hFFFF_0003, eh, el, edz);
    @(negedge clk);
    oper = 3'd0; opa = 32'h0001_2345; opb = 32'hFFFF_0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      if (cyc == 5) begin oper = 3'd3; opa = 32'd99; opb = 32'd4; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++; if (cyc !== 34) begin errors++; $display("FAIL ignore_latency got=%0d exp=34", cyc); end
    checks++; if ({hi, lo} !== {eh, el}) begin errors++; $display("FAIL ignore_result got=%h_%h exp=%h_%h", hi, lo, eh, el); end
  endtask

  task automatic test_flush(input int flush_at, input string nm);
    logic [31:0] ph, pl;
    logic saw_done;
    ph = hi; pl = lo;
    @(negedge clk);
    oper = 3'd1; opa = $urandom; opb = $urandom | 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < flush_at; c++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got=%b exp=0", nm, busy); end
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL %s_done got=1 exp=0", nm); end
    checks++; if ({hi, lo} !== {ph, pl}) begin errors++; $display("FAIL %s_hilo got=%h_%h exp=%h_%h", nm, hi, lo, ph, pl); end
  endtask

  task automatic test_stall();
    int lat, bc;
    logic [31:0] h, l;
    logic dzv, da, dza;
    run_op(3'd3, 32'd100, 32'd7, 10, 5, lat, bc, h, l, dzv, da, dza);
    checks++; if (lat !== 39) begin errors++; $display("FAIL stall_latency got=%0d exp=39", lat); end
    checks++; if (bc !== 38) begin errors++; $display("FAIL stall_busy_cycles got=%0d exp=38", bc); end
    checks++; if (l !== 32'd14 || h !== 32'd2) begin errors++; $display("FAIL stall_result got=%h_%h exp=00000002_0000000e", h, l); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL stall_done_pulse got=%b exp=0", da); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    oper = 3'd4; opa = 32'hA5A5_5A5A; start = 1'b1;
    @(negedge clk);
    oper = 3'd3; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 12; c++) @(negedge clk);
    cpu_rst = 1'b1;
    @(negedge clk);
    cpu_rst = 1'b0;
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi, lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_busy_done got=%b%b exp=00", busy, done); end
    repeat (40) @(negedge clk);
    checks++; if (done !== 1'b0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_no_result got=%b_%h exp=0_0", done, lo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt();
    test_random();
    test_ignore_start();
    test_flush(10, "flush_run");
    test_flush(33, "flush_fix");
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
